sc_levelseq_vehicles: RTL and testbench
=======================================

// Module: sc_levelseq_vehicles
// PURPOSE
//  Parametrised level sequencer for the vehicle lanes. It selects one of NUM_LEVELS patterns.
//  It drives the load/shift controls of the lane shift register and picks the lane speed
//  clock per level. Levels can advance on demand and the run can pause. It sits between
//  game control (start/level/pause) and the lane shift register plus clock dividers.
// PARAMETERS
//  DATAWIDTH_BUS   8                          pattern width
//  NUM_LEVELS      4                          number of levels (>=2)
//  LEVEL_W         2                          level index width, >= clog2(NUM_LEVELS)
//  NUM_SPEEDS      3                          speed clocks; CLKSEL_W = 2 fixed (sel 1..3)
//  LEVEL_PATTERNS  {8'hF0,8'hCC,8'hAA,8'h81}  packed; level i in bits [i*DATAWIDTH_BUS +: DATAWIDTH_BUS]
//  LEVEL_CLKSEL    {2'd3,2'd3,2'd2,2'd1}      packed; level i speed select in bits [i*2 +: 2]
//  LOAD_TIMEOUT    15                         LOAD cycles before abort (option only)
// PORTS
//  SC_LEVELSEQ_VEH_CLOCK_50         in   1        system clock
//  SC_LEVELSEQ_VEH_RESET            in   1        synchronous, active-high reset
//  SC_LEVELSEQ_VEH_NVL_IN           in   LEVEL_W  requested start level
//  SC_LEVELSEQ_VEH_CN_IN            in   1        start (IDLE) / stop (RUN, PAUSE)
//  SC_LEVELSEQ_VEH_LEVELUP_IN       in   1        advance one level while in RUN
//  SC_LEVELSEQ_VEH_PAUSE_IN         in   1        level-sensitive pause request
//  SC_LEVELSEQ_VEH_LOADED_IN        in   1        shift register confirms load
//  SC_LEVELSEQ_VEH_LOAD_OUT         out  1        parallel-load enable
//  SC_LEVELSEQ_VEH_SHIFT_OUT        out  1        shift enable
//  SC_LEVELSEQ_VEH_REGNIVEL_OUT     out  DATAWIDTH_BUS  pattern to load
//  SC_LEVELSEQ_VEH_CLOCK_SELECT     out  2        speed-clock mux select
//  SC_LEVELSEQ_VEH_HAB_CLOCK_OUT    out  NUM_SPEEDS  one-hot divider enables
//  SC_LEVELSEQ_VEH_LEVEL_OUT        out  LEVEL_W  current level index
//  SC_LEVELSEQ_VEH_ERROR_OUT        out  1        1-cycle load-timeout pulse
// BEHAVIOUR
//  - The FSM is IDLE, LOAD, RUN, PAUSE. State and level index are registered. Outputs other than ERROR decode the state (Moore).
//  - Reset (sync) sets state IDLE, level 0 and counter 0. Outputs: LOAD=1, SHIFT=0, REGNIVEL=0, CLOCK_SELECT=0, HAB=0, LEVEL=0, ERROR=0.
//  - IDLE: LOAD=1, SHIFT=0, REGNIVEL=0, SEL=0, HAB=0. When CN_IN=1, the level latches NVL_IN, clamped to NUM_LEVELS-1, and the FSM goes to LOAD.
//  - LOAD: LOAD=1, SHIFT=0, REGNIVEL=pattern[level], SEL=0, HAB=0. When LOADED_IN=1, the FSM goes to RUN on the next edge.
//  - RUN: LOAD=0, SHIFT=1, REGNIVEL=0, SEL=clksel[level], and HAB bit (NUM_SPEEDS-sel) is set (sel 0 gives HAB=0).
//    Priority: CN_IN -> IDLE; else LEVELUP_IN -> level+1 (saturates at NUM_LEVELS-1) and LOAD; else PAUSE_IN -> PAUSE.
//  - PAUSE: same as RUN but SHIFT=0 and HAB=0, with SEL held. CN_IN -> IDLE; else PAUSE_IN=0 -> RUN. LEVELUP_IN is ignored.
//  - Level-up at the top level still reloads the same pattern (LOAD pass).
//  - Latency: one edge per transition. First SHIFT=1 is on the cycle after the edge that samples LOADED_IN=1.
//  - Inputs are sampled only in the states listed; elsewhere they are ignored.
//  - Reset in any state takes effect on the next edge, overriding all inputs.
// CONFIGURATION
//  SC_LEVELSEQ_VEH_LOADTIMEOUT_EN defined: an 8-bit counter clears on LOAD entry and counts each LOAD cycle.
//    If LOADED_IN is still 0 when the count reaches LOAD_TIMEOUT, the FSM goes to IDLE, level resets to 0, and ERROR_OUT=1 for one cycle.
//    LOADED_IN=1 on the same cycle as the timeout wins: the FSM goes to RUN and no error is flagged.
//  Undefined: LOAD waits indefinitely, no counter is built, ERROR_OUT is tied 0.
// TESTING
//  1 Reset, NVL=2, CN pulse, LOADED after 3 cycles -> REGNIVEL=8'hCC in LOAD; then RUN with SEL=3, HAB=3'b001, SHIFT=1.
//  2 In RUN at level 0, LEVELUP -> LOAD with REGNIVEL=8'hAA, LEVEL=1; after LOADED -> SEL=2, HAB=3'b010.
//  3 At level 3, LEVELUP -> LOAD, REGNIVEL=8'hF0, LEVEL stays 3.
//  4 In RUN, PAUSE=1 -> SHIFT=0, HAB=0, SEL held. PAUSE=0 -> RUN resumes. CN+PAUSE together in RUN -> IDLE.
//  5 NVL=3 with NUM_LEVELS=3 -> LEVEL=2 (clamped). Reset asserted in RUN -> next cycle all outputs at reset values.
//  6 (_EN) LOADED held 0 -> after 15 LOAD cycles ERROR=1 for one cycle and the FSM returns to IDLE. LOADED on cycle 15 -> RUN, ERROR=0.

Source files
------------

// File: rtl/sc_levelseq_vehicles.sv
// -----------------------------------------------------------------------------
// sc_levelseq_vehicles
//   Level sequencer for the vehicle lanes. It picks one of NUM_LEVELS lane
//   patterns and drives the lane shift register's parallel-load and shift
//   enables. It also selects the lane speed clock for the current level.
//   Game control starts and stops a run, can advance the level on demand, and
//   can pause the lanes.
//
// Optional feature (compile-time macro SC_LEVELSEQ_VEH_LOADTIMEOUT_EN):
//   When the macro is defined, the LOAD state gives up after LOAD_TIMEOUT cycles
//   without a load confirmation. The sequencer then returns to IDLE at level 0
//   and pulses ERROR_OUT for one cycle.
//   When the macro is undefined, LOAD waits indefinitely and ERROR_OUT is tied
//   low.
//
// Ports
//   SC_LEVELSEQ_VEH_CLOCK_50      in   1              system clock
//   SC_LEVELSEQ_VEH_RESET         in   1              synchronous, active-high reset
//   SC_LEVELSEQ_VEH_NVL_IN        in   LEVEL_W        requested start level
//   SC_LEVELSEQ_VEH_CN_IN         in   1              start (IDLE) / stop (RUN, PAUSE)
//   SC_LEVELSEQ_VEH_LEVELUP_IN    in   1              advance one level while running
//   SC_LEVELSEQ_VEH_PAUSE_IN      in   1              level-sensitive pause request
//   SC_LEVELSEQ_VEH_LOADED_IN     in   1              shift register confirms the load
//   SC_LEVELSEQ_VEH_LOAD_OUT      out  1              parallel-load enable
//   SC_LEVELSEQ_VEH_SHIFT_OUT     out  1              shift enable
//   SC_LEVELSEQ_VEH_REGNIVEL_OUT  out  DATAWIDTH_BUS  pattern to load
//   SC_LEVELSEQ_VEH_CLOCK_SELECT  out  2              speed-clock mux select
//   SC_LEVELSEQ_VEH_HAB_CLOCK_OUT out  NUM_SPEEDS     one-hot divider enables
//   SC_LEVELSEQ_VEH_LEVEL_OUT     out  LEVEL_W        current level index
//   SC_LEVELSEQ_VEH_ERROR_OUT     out  1              one-cycle load-timeout pulse
// -----------------------------------------------------------------------------
module sc_levelseq_vehicles #(
    parameter int DATAWIDTH_BUS = 8,
    parameter int NUM_LEVELS    = 4,
    parameter int LEVEL_W       = 2,
    parameter int NUM_SPEEDS    = 3,
    parameter logic [NUM_LEVELS*DATAWIDTH_BUS-1:0] LEVEL_PATTERNS = {8'hF0, 8'hCC, 8'hAA, 8'h81},
    parameter logic [NUM_LEVELS*2-1:0]             LEVEL_CLKSEL   = {2'd3, 2'd3, 2'd2, 2'd1},
    parameter int LOAD_TIMEOUT  = 15
) (
    input  logic                     SC_LEVELSEQ_VEH_CLOCK_50,
    input  logic                     SC_LEVELSEQ_VEH_RESET,
    input  logic [LEVEL_W-1:0]       SC_LEVELSEQ_VEH_NVL_IN,
    input  logic                     SC_LEVELSEQ_VEH_CN_IN,
    input  logic                     SC_LEVELSEQ_VEH_LEVELUP_IN,
    input  logic                     SC_LEVELSEQ_VEH_PAUSE_IN,
    input  logic                     SC_LEVELSEQ_VEH_LOADED_IN,
    output logic                     SC_LEVELSEQ_VEH_LOAD_OUT,
    output logic                     SC_LEVELSEQ_VEH_SHIFT_OUT,
    output logic [DATAWIDTH_BUS-1:0] SC_LEVELSEQ_VEH_REGNIVEL_OUT,
    output logic [1:0]               SC_LEVELSEQ_VEH_CLOCK_SELECT,
    output logic [NUM_SPEEDS-1:0]    SC_LEVELSEQ_VEH_HAB_CLOCK_OUT,
    output logic [LEVEL_W-1:0]       SC_LEVELSEQ_VEH_LEVEL_OUT,
    output logic                     SC_LEVELSEQ_VEH_ERROR_OUT
);

    // Reject parameter sets that cannot work.
    if (NUM_LEVELS < 2) begin : g_chk_levels
        $error("sc_levelseq_vehicles: NUM_LEVELS must be at least 2");
    end
    if (LOAD_TIMEOUT < 1 || LOAD_TIMEOUT > 255) begin : g_chk_timeout
        $error("sc_levelseq_vehicles: LOAD_TIMEOUT must be in 1..255");
    end

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_LOAD  = 2'd1,
        S_RUN   = 2'd2,
        S_PAUSE = 2'd3
    } state_t;

    localparam logic [LEVEL_W-1:0] LVL_MAX = LEVEL_W'(NUM_LEVELS - 1);

    state_t               r_state;
    state_t               w_state_nxt;
    logic [LEVEL_W-1:0]   r_level;
    logic [LEVEL_W-1:0]   w_level_nxt;
    logic [LEVEL_W-1:0]   w_nvl_clamped;
    logic [1:0]           w_level_sel;
    logic [NUM_SPEEDS-1:0] w_hab_run;

`ifdef SC_LEVELSEQ_VEH_LOADTIMEOUT_EN
    localparam logic [7:0] TIMEOUT_CNT = 8'(LOAD_TIMEOUT);
    logic [7:0] r_load_cnt;
    logic       r_error;
    logic       w_timeout;
`endif

    // A requested start level beyond the last level is clamped to the last one.
    assign w_nvl_clamped = (SC_LEVELSEQ_VEH_NVL_IN > LVL_MAX) ? LVL_MAX : SC_LEVELSEQ_VEH_NVL_IN;

    // Speed select for the current level. HAB enables divider (NUM_SPEEDS - sel).
    // A select of 0 enables no divider.
    assign w_level_sel = LEVEL_CLKSEL[int'(r_level)*2 +: 2];

    always_comb begin
        w_hab_run = '0;
        for (int i = 0; i < NUM_SPEEDS; i++) begin
            w_hab_run[i] = (w_level_sel != 2'd0) && (i == NUM_SPEEDS - int'(w_level_sel));
        end
    end

    // Next-state logic
    always_comb begin
        w_state_nxt = r_state;
        w_level_nxt = r_level;
`ifdef SC_LEVELSEQ_VEH_LOADTIMEOUT_EN
        w_timeout   = 1'b0;
`endif
        case (r_state)
            S_IDLE: begin
                if (SC_LEVELSEQ_VEH_CN_IN) begin
                    w_level_nxt = w_nvl_clamped;
                    w_state_nxt = S_LOAD;
                end
            end
            S_LOAD: begin
                // A confirmation that arrives on the timeout cycle still wins.
                if (SC_LEVELSEQ_VEH_LOADED_IN) begin
                    w_state_nxt = S_RUN;
                end
`ifdef SC_LEVELSEQ_VEH_LOADTIMEOUT_EN
                else if ((r_load_cnt + 8'd1) == TIMEOUT_CNT) begin
                    w_state_nxt = S_IDLE;
                    w_level_nxt = '0;
                    w_timeout   = 1'b1;
                end
`endif
            end
            S_RUN: begin
                if (SC_LEVELSEQ_VEH_CN_IN) begin
                    w_state_nxt = S_IDLE;
                end else if (SC_LEVELSEQ_VEH_LEVELUP_IN) begin
                    // At the top level this still makes a LOAD pass with the same pattern.
                    w_level_nxt = (r_level == LVL_MAX) ? LVL_MAX : r_level + 1'b1;
                    w_state_nxt = S_LOAD;
                end else if (SC_LEVELSEQ_VEH_PAUSE_IN) begin
                    w_state_nxt = S_PAUSE;
                end
            end
            S_PAUSE: begin
                if (SC_LEVELSEQ_VEH_CN_IN) begin
                    w_state_nxt = S_IDLE;
                end else if (!SC_LEVELSEQ_VEH_PAUSE_IN) begin
                    w_state_nxt = S_RUN;
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge SC_LEVELSEQ_VEH_CLOCK_50) begin
        if (SC_LEVELSEQ_VEH_RESET) begin
            r_state <= S_IDLE;
            r_level <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_level <= w_level_nxt;
        end
    end

`ifdef SC_LEVELSEQ_VEH_LOADTIMEOUT_EN
    // The counter is held at zero outside LOAD, so it starts from zero on
    // every LOAD entry. It counts LOAD cycles already completed.
    always_ff @(posedge SC_LEVELSEQ_VEH_CLOCK_50) begin
        if (SC_LEVELSEQ_VEH_RESET) begin
            r_load_cnt <= '0;
            r_error    <= 1'b0;
        end else begin
            r_load_cnt <= (r_state == S_LOAD) ? r_load_cnt + 8'd1 : 8'd0;
            r_error    <= w_timeout;
        end
    end

    assign SC_LEVELSEQ_VEH_ERROR_OUT = r_error;
`else
    assign SC_LEVELSEQ_VEH_ERROR_OUT = 1'b0;
`endif

    // Moore output decode
    always_comb begin
        SC_LEVELSEQ_VEH_LOAD_OUT      = 1'b0;
        SC_LEVELSEQ_VEH_SHIFT_OUT     = 1'b0;
        SC_LEVELSEQ_VEH_REGNIVEL_OUT  = '0;
        SC_LEVELSEQ_VEH_CLOCK_SELECT  = 2'd0;
        SC_LEVELSEQ_VEH_HAB_CLOCK_OUT = '0;
        case (r_state)
            S_IDLE: begin
                SC_LEVELSEQ_VEH_LOAD_OUT = 1'b1;
            end
            S_LOAD: begin
                SC_LEVELSEQ_VEH_LOAD_OUT     = 1'b1;
                SC_LEVELSEQ_VEH_REGNIVEL_OUT = LEVEL_PATTERNS[int'(r_level)*DATAWIDTH_BUS +: DATAWIDTH_BUS];
            end
            S_RUN: begin
                SC_LEVELSEQ_VEH_SHIFT_OUT     = 1'b1;
                SC_LEVELSEQ_VEH_CLOCK_SELECT  = w_level_sel;
                SC_LEVELSEQ_VEH_HAB_CLOCK_OUT = w_hab_run;
            end
            S_PAUSE: begin
                SC_LEVELSEQ_VEH_CLOCK_SELECT = w_level_sel;
            end
            default: begin
                SC_LEVELSEQ_VEH_LOAD_OUT = 1'b1;
            end
        endcase
    end

    assign SC_LEVELSEQ_VEH_LEVEL_OUT = r_level;

endmodule

// File: tb/tb_sc_levelseq_vehicles.sv
module tb_sc_levelseq_vehicles;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst, cn, lvup, pause, loaded;
    logic [1:0] nvl;

    // Instance A: default four levels.
    logic       a_load, a_shift, a_err;
    logic [7:0] a_reg;
    logic [1:0] a_sel, a_lvl;
    logic [2:0] a_hab;
    // Instance B: three levels, exercising the start-level clamp.
    logic       b_load, b_shift, b_err;
    logic [7:0] b_reg;
    logic [1:0] b_sel, b_lvl;
    logic [2:0] b_hab;

    sc_levelseq_vehicles dut_a (
        .SC_LEVELSEQ_VEH_CLOCK_50     (clk),
        .SC_LEVELSEQ_VEH_RESET        (rst),
        .SC_LEVELSEQ_VEH_NVL_IN       (nvl),
        .SC_LEVELSEQ_VEH_CN_IN        (cn),
        .SC_LEVELSEQ_VEH_LEVELUP_IN   (lvup),
        .SC_LEVELSEQ_VEH_PAUSE_IN     (pause),
        .SC_LEVELSEQ_VEH_LOADED_IN    (loaded),
        .SC_LEVELSEQ_VEH_LOAD_OUT     (a_load),
        .SC_LEVELSEQ_VEH_SHIFT_OUT    (a_shift),
        .SC_LEVELSEQ_VEH_REGNIVEL_OUT (a_reg),
        .SC_LEVELSEQ_VEH_CLOCK_SELECT (a_sel),
        .SC_LEVELSEQ_VEH_HAB_CLOCK_OUT(a_hab),
        .SC_LEVELSEQ_VEH_LEVEL_OUT    (a_lvl),
        .SC_LEVELSEQ_VEH_ERROR_OUT    (a_err)
    );

    sc_levelseq_vehicles #(
        .NUM_LEVELS    (3),
        .LEVEL_W       (2),
        .LEVEL_PATTERNS({8'hCC, 8'hAA, 8'h81}),
        .LEVEL_CLKSEL  ({2'd3, 2'd2, 2'd1})
    ) dut_b (
        .SC_LEVELSEQ_VEH_CLOCK_50     (clk),
        .SC_LEVELSEQ_VEH_RESET        (rst),
        .SC_LEVELSEQ_VEH_NVL_IN       (nvl),
        .SC_LEVELSEQ_VEH_CN_IN        (cn),
        .SC_LEVELSEQ_VEH_LEVELUP_IN   (lvup),
        .SC_LEVELSEQ_VEH_PAUSE_IN     (pause),
        .SC_LEVELSEQ_VEH_LOADED_IN    (loaded),
        .SC_LEVELSEQ_VEH_LOAD_OUT     (b_load),
        .SC_LEVELSEQ_VEH_SHIFT_OUT    (b_shift),
        .SC_LEVELSEQ_VEH_REGNIVEL_OUT (b_reg),
        .SC_LEVELSEQ_VEH_CLOCK_SELECT (b_sel),
        .SC_LEVELSEQ_VEH_HAB_CLOCK_OUT(b_hab),
        .SC_LEVELSEQ_VEH_LEVEL_OUT    (b_lvl),
        .SC_LEVELSEQ_VEH_ERROR_OUT    (b_err)
    );

    int checks   = 0;
    int failures = 0;

    // Reference model: run mode, level and load-cycle count per instance.
    localparam int M_IDLE  = 0;
    localparam int M_LOAD  = 1;
    localparam int M_RUN   = 2;
    localparam int M_PAUSE = 3;
    localparam int TIMEOUT = 15;

    logic [7:0] pat  [0:3] = '{8'h81, 8'hAA, 8'hCC, 8'hF0};
    int         csel [0:3] = '{1, 2, 3, 3};

    int m_mode [0:1] = '{M_IDLE, M_IDLE};
    int m_lvl  [0:1] = '{0, 0};
    int m_cnt  [0:1] = '{0, 0};
    int m_err  [0:1] = '{0, 0};

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic mdl_step(input int k, input int nl);
        int top;
        top = nl - 1;
        m_err[k] = 0;
        if (rst) begin
            m_mode[k] = M_IDLE;
            m_lvl[k]  = 0;
            m_cnt[k]  = 0;
        end else begin
            case (m_mode[k])
                M_IDLE: if (cn) begin
                    m_lvl[k]  = (int'(nvl) > top) ? top : int'(nvl);
                    m_mode[k] = M_LOAD;
                    m_cnt[k]  = 0;
                end
                M_LOAD: begin
                    if (loaded) begin
                        m_mode[k] = M_RUN;
                    end else begin
                        m_cnt[k]++;
`ifdef SC_LEVELSEQ_VEH_LOADTIMEOUT_EN
                        if (m_cnt[k] == TIMEOUT) begin
                            m_mode[k] = M_IDLE;
                            m_lvl[k]  = 0;
                            m_err[k]  = 1;
                        end
`endif
                    end
                end
                M_RUN: begin
                    if (cn) m_mode[k] = M_IDLE;
                    else if (lvup) begin
                        m_lvl[k]  = (m_lvl[k] + 1 > top) ? top : m_lvl[k] + 1;
                        m_mode[k] = M_LOAD;
                        m_cnt[k]  = 0;
                    end else if (pause) m_mode[k] = M_PAUSE;
                end
                default: begin
                    if (cn) m_mode[k] = M_IDLE;
                    else if (!pause) m_mode[k] = M_RUN;
                end
            endcase
        end
    endtask

    task automatic chk_out(input int k);
        string p;
        int    md, lv, e_sel;
        logic [31:0] o_ld, o_sh, o_rg, o_sl, o_hb, o_lv, o_er;
        md = m_mode[k];
        lv = m_lvl[k];
        p  = (k == 0) ? "A" : "B";
        if (k == 0) begin
            o_ld = 32'(a_load); o_sh = 32'(a_shift); o_rg = 32'(a_reg); o_sl = 32'(a_sel);
            o_hb = 32'(a_hab);  o_lv = 32'(a_lvl);   o_er = 32'(a_err);
        end else begin
            o_ld = 32'(b_load); o_sh = 32'(b_shift); o_rg = 32'(b_reg); o_sl = 32'(b_sel);
            o_hb = 32'(b_hab);  o_lv = 32'(b_lvl);   o_er = 32'(b_err);
        end
        e_sel = (md == M_RUN || md == M_PAUSE) ? csel[lv] : 0;
        chk({p, "_load"},  o_ld, 32'(md == M_IDLE || md == M_LOAD));
        chk({p, "_shift"}, o_sh, 32'(md == M_RUN));
        chk({p, "_reg"},   o_rg, (md == M_LOAD) ? 32'(pat[lv]) : 32'd0);
        chk({p, "_sel"},   o_sl, 32'(e_sel));
        chk({p, "_hab"},   o_hb, (md == M_RUN) ? (32'd1 << (3 - e_sel)) : 32'd0);
        chk({p, "_level"}, o_lv, 32'(lv));
        chk({p, "_err"},   o_er, 32'(m_err[k]));
    endtask

    task automatic step();
        @(posedge clk);
        mdl_step(0, 4);
        mdl_step(1, 3);
        #1;
        chk_out(0);
        chk_out(1);
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, "_load"},  32'(a_load),  32'd1);
        chk({tag, "_shift"}, 32'(a_shift), 32'd0);
        chk({tag, "_reg"},   32'(a_reg),   32'd0);
        chk({tag, "_sel"},   32'(a_sel),   32'd0);
        chk({tag, "_hab"},   32'(a_hab),   32'd0);
        chk({tag, "_level"}, 32'(a_lvl),   32'd0);
        chk({tag, "_err"},   32'(a_err),   32'd0);
    endtask

    initial begin
        rst = 1'b1; cn = 1'b0; lvup = 1'b0; pause = 1'b0; loaded = 1'b0; nvl = 2'd0;
        step();
        chk_reset_vals("rst0");
        rst = 1'b0;
        step();

        // Start at level 2, confirm the load after three LOAD cycles.
        nvl = 2'd2; cn = 1'b1;
        step();
        cn = 1'b0;
        chk("t1_reg_cc", 32'(a_reg), 32'h0000_00CC);
        chk("t1_level", 32'(a_lvl), 32'd2);
        step(); step(); step();
        loaded = 1'b1;
        step();
        loaded = 1'b0;
        chk("t1_shift", 32'(a_shift), 32'd1);
        chk("t1_sel", 32'(a_sel), 32'd3);
        chk("t1_hab", 32'(a_hab), 32'b001);

        // Pause, resume, then stop while pausing.
        pause = 1'b1;
        step();
        chk("t4_pause_shift", 32'(a_shift), 32'd0);
        chk("t4_pause_hab", 32'(a_hab), 32'd0);
        chk("t4_pause_sel", 32'(a_sel), 32'd3);
        pause = 1'b0;
        step();
        chk("t4_resume_shift", 32'(a_shift), 32'd1);
        cn = 1'b1; pause = 1'b1;
        step();
        cn = 1'b0; pause = 1'b0;
        chk("t4_cn_idle_load", 32'(a_load), 32'd1);
        chk("t4_cn_idle_shift", 32'(a_shift), 32'd0);

        // Level 0 run, then level up to 1.
        nvl = 2'd0; cn = 1'b1;
        step();
        cn = 1'b0; loaded = 1'b1;
        step();
        loaded = 1'b0; lvup = 1'b1;
        step();
        lvup = 1'b0;
        chk("t2_reg_aa", 32'(a_reg), 32'h0000_00AA);
        chk("t2_level", 32'(a_lvl), 32'd1);
        loaded = 1'b1;
        step();
        loaded = 1'b0;
        chk("t2_sel", 32'(a_sel), 32'd2);
        chk("t2_hab", 32'(a_hab), 32'b010);

        // Climb to level 3, then level up at the top.
        repeat (2) begin
            lvup = 1'b1;   step();
            lvup = 1'b0; loaded = 1'b1; step();
            loaded = 1'b0;
        end
        lvup = 1'b1;
        step();
        lvup = 1'b0;
        chk("t3_reg_f0", 32'(a_reg), 32'h0000_00F0);
        chk("t3_level", 32'(a_lvl), 32'd3);
        loaded = 1'b1;
        step();
        loaded = 1'b0;

        // Stop, restart with level 3 (clamped on the three-level instance).
        cn = 1'b1;
        step();
        nvl = 2'd3;
        step();
        cn = 1'b0;
        chk("t5_clamp_b", 32'(b_lvl), 32'd2);
        chk("t5_noclamp_a", 32'(a_lvl), 32'd3);
        loaded = 1'b1;
        step();
        loaded = 1'b0;
        rst = 1'b1;
        step();
        rst = 1'b0;
        chk_reset_vals("t5_rst");

`ifdef SC_LEVELSEQ_VEH_LOADTIMEOUT_EN
        // Load never confirmed: timeout on the 15th LOAD cycle.
        nvl = 2'd1; cn = 1'b1;
        step();
        cn = 1'b0;
        repeat (TIMEOUT - 1) step();
        chk("t6_still_load", 32'(a_load), 32'd1);
        step();
        chk("t6_err", 32'(a_err), 32'd1);
        chk("t6_level0", 32'(a_lvl), 32'd0);
        step();
        chk("t6_err_clear", 32'(a_err), 32'd0);
        // Confirmation on the timeout cycle wins.
        cn = 1'b1;
        step();
        cn = 1'b0;
        repeat (TIMEOUT - 1) step();
        loaded = 1'b1;
        step();
        loaded = 1'b0;
        chk("t6_run", 32'(a_shift), 32'd1);
        chk("t6_noerr", 32'(a_err), 32'd0);
`endif

        // Randomized traffic against the model.
        for (int i = 0; i < 600; i++) begin
            rst    = ($urandom_range(0, 59) == 0);
            cn     = ($urandom_range(0, 7) == 0);
            lvup   = ($urandom_range(0, 5) == 0);
            pause  = ($urandom_range(0, 2) == 0);
            loaded = ($urandom_range(0, 3) == 0);
            nvl    = 2'($urandom_range(0, 3));
            step();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
